pdm_capture: RTL and testbench
==============================

Name: pdm_capture

Overview:
Front end of the voice-command path. It generates the PDM microphone clock, synchronises the 1-bit mic stream and decimates it by ones-counting over a fixed window into 8-bit samples. It packs four samples into one 32-bit word and pulses a one-cycle write strobe. The recorder/comparator control stage consumes the word as RAM write data and advances its RAM address on each strobe.

Parameters:
CLK_DIV, 42, sys clocks per mic_clk period (100 MHz / 42 ≈ 2.38 MHz); must be even and ≥ 4
DECIM, 240, mic_clk periods per sample (≈ 9.9 kHz sample rate)
SAMPLE_W, 8, bits per packed sample
PACK, 4, samples per output word

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  capture enable from control stage (its count_en)
mic_data  in  1  raw PDM data from microphone, asynchronous to clk
mic_clk  out  1  PDM clock to microphone
mic_lrsel  out  1  channel select, tied 0 (data valid at mic_clk rising edge)
word  out  PACK*SAMPLE_W  packed samples, sample k in bits [SAMPLE_W*k+SAMPLE_W-1 : SAMPLE_W*k]
word_valid  out  1  one-cycle strobe; word is valid in this cycle
sample_strobe  out  1  one-cycle pulse per completed sample (debug/metering)

Behaviour:
- Reset values: mic_clk=0, mic_lrsel=0, word=0, word_valid=0, sample_strobe=0. All counters are 0, sync flops are 0, state is IDLE.
- Clock divider: a free-running counter 0..CLK_DIV-1 that runs regardless of en. mic_clk=1 when count ≥ CLK_DIV/2, giving a 50% duty cycle.
  - tick = 1 for the single cycle in which the counter wraps to CLK_DIV/2, i.e. the mic_clk rising edge.
- Sync: mic_data passes through a 2-flop synchroniser. The synchronised bit is the one counted at each tick.
- Ones accumulator: width $clog2(DECIM+1).
  - On a tick it adds the sync bit; the tick counter counts 0..DECIM-1.
  - On the tick where the tick counter = DECIM-1: sample = min(ones + bit, 2^SAMPLE_W-1), which saturates.
  - The sample is written into lane pack_idx, and the accumulator and tick counter clear to 0.
  - sample_strobe pulses in the next cycle.
- Packer: pack_idx counts 0..PACK-1.
  - When lane PACK-1 is written, word (all lanes) is registered and word_valid=1 in the next cycle only. pack_idx then wraps to 0.
  - word holds its value until the next emission.
- FSM states:
  - IDLE: counters held at 0. Goes to ACCUM when en=1.
  - ACCUM: counting. Goes to EMIT on completion of the last lane. Goes to IDLE if en=0 at any cycle, discarding the partial window and partially filled lanes with no strobe.
  - EMIT: a single cycle that drives word_valid. Always returns to ACCUM if en=1, otherwise IDLE.
- en=0 in the EMIT cycle is legal and expected, because the control stage drops en while the strobe is high. It must not drop the emitted word. The next window starts cleanly.
- Ticks are ≥ 4 cycles apart, so a tick never coincides with EMIT.
- Latency: word_valid is 1 cycle after the tick closing the last window. The first word after en rises arrives after PACK*DECIM ticks (≈ 40320 cycles at defaults), plus up to CLK_DIV cycles of tick phase.
- Reset mid-operation clears everything immediately, with no strobe. mic_clk restarts low.
- en is assumed synchronous to clk.

Decomposition:
- Shared package voice_pkg holds:
  - SAMPLE_FREQ (10000)
  - default CLK_DIV / DECIM
  - PACK and SAMPLE_W
  - state enum capture_state_t {IDLE, ACCUM, EMIT}
- The control stage reuses the same SAMPLE_W/PACK constants from it.
- One sub-module, pdm_clkgen: divider producing mic_clk and tick. Synchroniser, accumulator, packer and FSM stay in pdm_capture.

Test Plan:
1. mic_data=1 constant, en=1 -> first word_valid after 960 ticks with word=0xF0F0F0F0; strobes exactly 1 cycle; repeats every 960 ticks.
2. mic_data=0 constant -> word=0x00000000. Alternating bit per tick -> every lane 0x78 (120).
3. Ramp stimulus with window w carrying w*60 ones (w=0..3) -> word=0xB4783C00, confirming lane order is LSB-first.
4. en dropped at tick 500 of lane 2, re-raised 100 cycles later -> no word_valid; next word built from fresh windows only, lane 0 first.
5. en driven low exactly in the word_valid cycle, high the cycle after (control-stage pattern) -> no word lost; subsequent words arrive every 960 ticks.
6. rst asserted mid-window -> outputs zero the same cycle; mic_clk period measured = 42 cycles, high time = 21; mic_lrsel=0 throughout.

Source files
------------

// File: rtl/voice_pkg.sv
// Shared constants and types for the voice-command path.
// Holds the sample format (SAMPLE_W, PACK) used by both the capture front end
// and the recorder/comparator control stage, the default PDM timing and the
// capture FSM state type. Also provides the sample saturation helper.
package voice_pkg;

  localparam int SAMPLE_FREQ     = 10000;
  localparam int CLK_DIV_DEFAULT = 42;
  localparam int DECIM_DEFAULT   = 240;
  localparam int SAMPLE_W        = 8;
  localparam int PACK            = 4;

  localparam int unsigned SAMPLE_MAX = (32'd1 << SAMPLE_W) - 32'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } capture_state_t;

  // Clamp a ones count to the largest value a sample lane can hold.
  function automatic logic [SAMPLE_W-1:0] sat_sample(input int unsigned ones);
    if (ones > SAMPLE_MAX) begin
      sat_sample = SAMPLE_W'(SAMPLE_MAX);
    end else begin
      sat_sample = SAMPLE_W'(ones);
    end
  endfunction

endpackage

// File: rtl/pdm_clkgen.sv
// PDM microphone clock generator.
// A free-running counter 0..CLK_DIV-1 produces a 50% duty mic_clk (high for
// the upper half of the count) and a one-cycle tick marking the mic_clk rising
// edge. It runs whenever rst is low, independent of capture enable.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   mic_clk out  PDM clock to the microphone (registered)
//   tick    out  one-cycle pulse in the cycle mic_clk goes high (registered)
module pdm_clkgen
  import voice_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic mic_clk,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Next divider count with wrap at CLK_DIV-1.
  always_comb begin
    if (count == LAST) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(1);
    end
  end

  // Divider state; outputs are decoded from the next count so they line up
  // with the count value held in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      mic_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      count   <= count_next;
      mic_clk <= (count_next >= HALF);
      tick    <= (count_next == HALF);
    end
  end

endmodule

// File: rtl/pdm_capture.sv
// PDM capture front end: mic clock generation, 2-flop synchronisation of the
// mic stream, ones-count decimation over DECIM mic clocks into SAMPLE_W-bit
// samples, and packing of PACK samples (lane 0 in the LSBs) into one word.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   en            in   capture enable from the control stage
//   mic_data      in   raw PDM data, asynchronous to clk
//   mic_clk       out  PDM clock to the microphone
//   mic_lrsel     out  channel select, tied low (data valid at mic_clk rise)
//   word          out  packed samples, held until the next emission
//   word_valid    out  one-cycle strobe, word valid in this cycle
//   sample_strobe out  one-cycle pulse per completed sample
module pdm_capture
  import voice_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int DECIM   = DECIM_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     mic_data,
  output logic                     mic_clk,
  output logic                     mic_lrsel,
  output logic [PACK*SAMPLE_W-1:0] word,
  output logic                     word_valid,
  output logic                     sample_strobe
);

  localparam int AW = $clog2(DECIM + 1);
  localparam int TW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DECIM - 1);
  localparam logic [PW-1:0] LANE_LAST = PW'(PACK - 1);

  logic tick;
  logic sync1;
  logic sync2;

  capture_state_t state;
  logic [AW-1:0] ones;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] pack_idx;
  logic [PACK-1:0][SAMPLE_W-1:0] lanes;
  logic [PACK-1:0][SAMPLE_W-1:0] lanes_next;

  logic [AW-1:0]       ones_sum;
  logic [SAMPLE_W-1:0] sample_val;

  pdm_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .mic_clk (mic_clk),
    .tick    (tick)
  );

  assign mic_lrsel = 1'b0;

  // The bit being counted is included in the closing sample, hence the sum.
  assign ones_sum   = ones + AW'(sync2);
  assign sample_val = sat_sample(32'(ones_sum));

  // Lane set with the current sample dropped into lane pack_idx.
  always_comb begin
    lanes_next           = lanes;
    lanes_next[pack_idx] = sample_val;
  end

  // Two-flop synchroniser for the asynchronous mic stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= mic_data;
      sync2 <= sync1;
    end
  end

  // Capture FSM with accumulator, packer and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ones          <= '0;
      tick_cnt      <= '0;
      pack_idx      <= '0;
      lanes         <= '0;
      word          <= '0;
      word_valid    <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      word_valid    <= 1'b0;
      sample_strobe <= 1'b0;
      case (state)
        IDLE: begin
          ones     <= '0;
          tick_cnt <= '0;
          pack_idx <= '0;
          lanes    <= '0;
          if (en) begin
            state <= ACCUM;
          end else begin
            state <= IDLE;
          end
        end
        ACCUM: begin
          if (!en) begin
            // Abandon the partial window and any partially filled lanes.
            ones     <= '0;
            tick_cnt <= '0;
            pack_idx <= '0;
            lanes    <= '0;
            state    <= IDLE;
          end else if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              lanes         <= lanes_next;
              ones          <= '0;
              tick_cnt      <= '0;
              sample_strobe <= 1'b1;
              if (pack_idx == LANE_LAST) begin
                word       <= lanes_next;
                word_valid <= 1'b1;
                pack_idx   <= '0;
                state      <= EMIT;
              end else begin
                pack_idx <= pack_idx + PW'(1);
              end
            end else begin
              ones     <= ones_sum;
              tick_cnt <= tick_cnt + TW'(1);
            end
          end else begin
            state <= ACCUM;
          end
        end
        EMIT: begin
          // The word is already registered, so dropping en here loses nothing.
          if (en) begin
            state <= ACCUM;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          ones     <= '0;
          tick_cnt <= '0;
          pack_idx <= '0;
          lanes    <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_capture.sv
// Self-checking bench for pdm_capture. A fast instance (CLK_DIV=4, DECIM=240)
// carries the word/strobe scoreboard; a default-parameter instance is used for
// mic_clk timing and reset behaviour. A per-window reference model pushes the
// expected words and strobe cycles; a monitor pops and compares.
module tb_pdm_capture;
  import voice_pkg::*;

  localparam int DIV_S    = 4;
  localparam int DIV_D    = 42;
  localparam int DEC      = 240;
  localparam int WORD_GAP = PACK * DEC * DIV_S;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic mic_data = 1'b0;

  logic s_mic_clk, s_mic_lrsel, s_word_valid, s_sample_strobe;
  logic [31:0] s_word;
  logic d_mic_clk, d_mic_lrsel, d_word_valid, d_sample_strobe;
  logic [31:0] d_word;

  pdm_capture #(.CLK_DIV(DIV_S), .DECIM(DEC)) dut (
    .clk(clk), .rst(rst), .en(en), .mic_data(mic_data),
    .mic_clk(s_mic_clk), .mic_lrsel(s_mic_lrsel), .word(s_word),
    .word_valid(s_word_valid), .sample_strobe(s_sample_strobe)
  );

  pdm_capture dut_def (
    .clk(clk), .rst(rst), .en(en), .mic_data(mic_data),
    .mic_clk(d_mic_clk), .mic_lrsel(d_mic_lrsel), .word(d_word),
    .word_valid(d_word_valid), .sample_strobe(d_sample_strobe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model state
  int mcnt_s = 0;
  int mcnt_d = 0;
  int m_ones = 0;
  int m_tcnt = 0;
  int m_lane = 0;
  bit prev_en = 1'b0;
  bit emit_now = 1'b0;
  logic [7:0] m_lanes [PACK];
  logic [31:0] exp_words [$];
  int exp_wcyc [$];
  int exp_scyc [$];

  // stimulus state: 0 const0, 1 const1, 2 alternating, 3 ramp, 4 random
  int mode = 0;
  bit cur_bit = 1'b0;

  // monitor results
  int words_seen = 0;
  logic [31:0] last_word = 32'd0;
  int last_wcyc = 0;
  int prev_wcyc = 0;
  bit prev_valid = 1'b0;
  bit prev_strb = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: one mic bit per mic_clk period; a tick counts only when
  // en was high on this edge and the one before; any low en discards progress.
  initial begin
    bit tick_now;
    int samp;
    logic [31:0] w;
    forever begin
      @(posedge clk);
      cyc++;
      emit_now = 1'b0;
      if (rst) begin
        mcnt_s = 0; mcnt_d = 0; m_ones = 0; m_tcnt = 0; m_lane = 0; prev_en = 1'b0;
        for (int k = 0; k < PACK; k++) m_lanes[k] = 8'd0;
        exp_words.delete(); exp_wcyc.delete(); exp_scyc.delete();
      end else begin
        tick_now = (mcnt_s == DIV_S / 2);
        mcnt_s = (mcnt_s + 1) % DIV_S;
        mcnt_d = (mcnt_d + 1) % DIV_D;
        if (!en) begin
          m_ones = 0; m_tcnt = 0; m_lane = 0; prev_en = 1'b0;
        end else begin
          if (prev_en && tick_now) begin
            m_ones += int'(cur_bit);
            if (m_tcnt == DEC - 1) begin
              samp = (m_ones > 255) ? 255 : m_ones;
              m_lanes[m_lane] = samp[7:0];
              exp_scyc.push_back(cyc);
              m_ones = 0;
              m_tcnt = 0;
              if (m_lane == PACK - 1) begin
                for (int k = 0; k < PACK; k++) w[k*SAMPLE_W +: SAMPLE_W] = m_lanes[k];
                exp_words.push_back(w);
                exp_wcyc.push_back(cyc);
                emit_now = 1'b1;
                m_lane = 0;
              end else begin
                m_lane++;
              end
            end else begin
              m_tcnt++;
            end
          end
          prev_en = 1'b1;
        end
      end
    end
  end

  // Mic data source: a new bit at the start of each mic_clk period.
  initial begin
    forever begin
      @(negedge clk);
      if (mcnt_s == 0) begin
        case (mode)
          0: cur_bit = 1'b0;
          1: cur_bit = 1'b1;
          2: cur_bit = ~cur_bit;
          3: cur_bit = (m_tcnt < m_lane * 60);
          default: cur_bit = 1'($urandom_range(0, 1));
        endcase
        mic_data = cur_bit;
      end
    end
  end

  // Monitor: clock outputs every cycle, words and strobes against the queues.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("mic_clk", {31'd0, s_mic_clk}, (!rst && mcnt_s >= DIV_S / 2) ? 32'd1 : 32'd0);
      check("mic_clk_def", {31'd0, d_mic_clk}, (!rst && mcnt_d >= DIV_D / 2) ? 32'd1 : 32'd0);
      check("mic_lrsel", {31'd0, s_mic_lrsel | d_mic_lrsel}, 32'd0);
      while (exp_wcyc.size() > 0 && exp_wcyc[0] < cyc) begin
        flag_fail("word_valid_missing");
        void'(exp_wcyc.pop_front());
        void'(exp_words.pop_front());
      end
      while (exp_scyc.size() > 0 && exp_scyc[0] < cyc) begin
        flag_fail("sample_strobe_missing");
        void'(exp_scyc.pop_front());
      end
      if (s_word_valid) begin
        check("word_valid_width", {31'd0, prev_valid}, 32'd0);
        if (exp_wcyc.size() == 0) begin
          flag_fail("word_valid_unexpected");
        end else begin
          check("word_valid_cycle", cyc, exp_wcyc.pop_front());
          check("word", s_word, exp_words.pop_front());
        end
        words_seen++;
        prev_wcyc = last_wcyc;
        last_wcyc = cyc;
        last_word = s_word;
      end
      if (s_sample_strobe) begin
        check("sample_strobe_width", {31'd0, prev_strb}, 32'd0);
        if (exp_scyc.size() == 0) begin
          flag_fail("sample_strobe_unexpected");
        end else begin
          check("sample_strobe_cycle", cyc, exp_scyc.pop_front());
        end
      end
      prev_valid = s_word_valid;
      prev_strb = s_sample_strobe;
    end
  end

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_words(input int n, input string tag);
    int target = words_seen + n;
    int t = 0;
    while (words_seen < target && t < 4500 * n) begin
      step();
      t++;
    end
    if (words_seen < target) flag_fail({"timeout_", tag});
  endtask

  task automatic restart(input int m);
    en = 1'b0;
    mode = m;
    repeat (8) step();
    en = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({"rst_word_", tag}, s_word | d_word, 32'd0);
    check({"rst_strobes_", tag},
          {28'd0, s_word_valid, s_sample_strobe, d_word_valid, d_sample_strobe}, 32'd0);
    check({"rst_mic_clk_", tag}, {30'd0, s_mic_clk, d_mic_clk}, 32'd0);
  endtask

  initial begin
    int ws;
    int t;
    int hi;
    int per;
    bit pv;
    bit found;

    repeat (3) step();
    check_reset_outputs("initial");
    rst = 1'b0;
    repeat (4) step();

    // constant ones: 240 per lane, words one full window set apart
    restart(1);
    wait_words(2, "const1");
    check("const1_word", last_word, 32'hF0F0_F0F0);
    check("const1_gap", last_wcyc - prev_wcyc, WORD_GAP);

    restart(0);
    wait_words(1, "const0");
    check("const0_word", last_word, 32'h0000_0000);

    restart(2);
    wait_words(1, "alternate");
    check("alt_word", last_word, 32'h7878_7878);

    restart(3);
    wait_words(1, "ramp");
    check("ramp_word", last_word, 32'hB478_3C00);

    restart(4);
    wait_words(1, "random");

    // drop en in the middle of lane 2, then rebuild from fresh windows
    t = 0;
    while (!(m_lane == 2 && m_tcnt == 20) && t < 5000) begin
      step();
      t++;
    end
    if (t >= 5000) flag_fail("timeout_lane2");
    ws = words_seen;
    en = 1'b0;
    mode = 3;
    repeat (100) step();
    en = 1'b1;
    check("no_word_while_disabled", words_seen, ws);
    wait_words(1, "after_drop");
    check("after_drop_word", last_word, 32'hB478_3C00);

    // control-stage pattern: en low only during the word_valid cycle
    mode = 4;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      found = 1'b0;
      while (!found && t < 4500) begin
        step();
        t++;
        found = emit_now;
      end
      if (!found) flag_fail("timeout_emit");
      en = 1'b0;
      step();
      en = 1'b1;
      check("ctrl_gap", last_wcyc - prev_wcyc, WORD_GAP);
    end

    // reset in the middle of a window
    mode = 1;
    t = 0;
    while (m_tcnt != 100 && t < 1000) begin
      step();
      t++;
    end
    if (t >= 1000) flag_fail("timeout_midwindow");
    rst = 1'b1;
    #1;
    check_reset_outputs("midwindow");
    repeat (3) step();
    rst = 1'b0;

    // mic_clk period and high time on the default instance
    t = 0;
    pv = d_mic_clk;
    found = 1'b0;
    while (!found && t < 200) begin
      step();
      t++;
      if (!pv && d_mic_clk) found = 1'b1;
      pv = d_mic_clk;
    end
    if (!found) flag_fail("timeout_mic_clk_rise");
    hi = 0;
    per = 0;
    found = 1'b0;
    while (!found && per < 200) begin
      if (d_mic_clk) hi++;
      per++;
      step();
      if (!pv && d_mic_clk) found = 1'b1;
      pv = d_mic_clk;
    end
    check("mic_clk_period", per, DIV_D);
    check("mic_clk_high", hi, DIV_D / 2);

    repeat (4) step();
    check("words_pending", exp_wcyc.size(), 32'd0);
    check("strobes_pending", exp_scyc.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #1500000;
    $display("FAIL watchdog: bench did not complete in time");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
